// File: rtl/mem_arb_pkg.sv
// Shared types for the cache/memory arbiter: RAM handshake states, arbiter
// FSM states, and default word/address types.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int WORD_W_DEF = 32;

    typedef logic [WORD_W_DEF-1:0] word_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    // Width of a core index; never zero so a single-core build still has a bit.
    function automatic int core_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_pick.sv
// Round-robin priority picker: first requesting slot at or after ptr_i,
// wrapping modulo N. Purely combinational.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o
);

    // Scan N slots starting at the pointer; the first hit wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Memory-side responder for CPUS icache/dcache pairs sharing one RAM port.
// Cores are picked round-robin; within a core the dcache beats the icache.
// Wait/load responses are combinational in the RAM ACCESS cycle.
module cache_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*ADDR_W-1:0]   iaddr,
    input  logic [CPUS*ADDR_W-1:0]   daddr,
    input  logic [CPUS*WORD_W-1:0]   dstore,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*WORD_W-1:0]   iload,
    output logic [CPUS*WORD_W-1:0]   dload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore,
    input  logic [WORD_W-1:0]        ramload,
    input  logic [1:0]               ramstate,
    output logic                     ram_err
);

    localparam int CW = core_w(CPUS);

    arb_state_t      state_q, state_d;
    logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   gnt_core_q, gnt_core_d;
    logic            gnt_is_d_q, gnt_is_d_d;
    logic            ram_err_q, ram_err_d;

    ramstate_t       rs;
    logic [CPUS-1:0] core_req;
    logic [CPUS-1:0] pick_gnt;
    logic            pick_valid;
    logic [CW-1:0]   pick_core;
    logic            pick_is_d;
    logic            gnt_live;
    logic [CW-1:0]   gnt_core_next;

    assign rs       = ramstate_t'(ramstate);
    assign core_req = iREN | dREN | dWEN;
    assign ram_err  = ram_err_q;

    rr_pick #(
        .N  (CPUS),
        .PW (CW)
    ) u_rr_pick (
        .req_i   (core_req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );

    // One-hot grant to core index; dcache of that core takes precedence.
    always_comb begin
        pick_core = '0;
        for (int c = 0; c < CPUS; c++) begin
            if (pick_gnt[c]) pick_core = CW'(c);
        end
        pick_is_d = dREN[pick_core] | dWEN[pick_core];
    end

    // Whether the granted source is still asserting, and the pointer after it.
    always_comb begin
        gnt_live      = gnt_is_d_q ? (dREN[gnt_core_q] | dWEN[gnt_core_q])
                                   : iREN[gnt_core_q];
        gnt_core_next = (gnt_core_q == CW'(CPUS - 1)) ? '0 : gnt_core_q + CW'(1);
    end

    // State, grant and sticky error registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_core_q <= '0;
            gnt_is_d_q <= 1'b0;
            ram_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_core_q <= gnt_core_d;
            gnt_is_d_q <= gnt_is_d_d;
            ram_err_q  <= ram_err_d;
        end
    end

    // Next-state: grant in IDLE, finish on ACCESS, abort if the request drops.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_core_d = gnt_core_q;
        gnt_is_d_d = gnt_is_d_q;
        ram_err_d  = ram_err_q | ((state_q == SERVE) && (rs == ERROR));
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_core_d = pick_core;
                    gnt_is_d_d = pick_is_d;
                    state_d    = SERVE;
                end
            end
            SERVE: begin
                if (!gnt_live) begin
                    state_d = IDLE;
                end else if (rs == ACCESS) begin
                    state_d  = IDLE;
                    rr_ptr_d = gnt_core_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: RAM mux from the granted source, response demux on ACCESS.
    always_comb begin
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state_q == SERVE && gnt_live) begin
            if (gnt_is_d_q) begin
                ramWEN   = dWEN[gnt_core_q];
                ramREN   = dREN[gnt_core_q] & ~dWEN[gnt_core_q];
                ramaddr  = daddr[int'(gnt_core_q)*ADDR_W +: ADDR_W];
                ramstore = dstore[int'(gnt_core_q)*WORD_W +: WORD_W];
                if (rs == ACCESS) begin
                    dwait[gnt_core_q] = 1'b0;
                    dload[int'(gnt_core_q)*WORD_W +: WORD_W] = ramload;
                end
            end else begin
                ramREN  = 1'b1;
                ramaddr = iaddr[int'(gnt_core_q)*ADDR_W +: ADDR_W];
                if (rs == ACCESS) begin
                    iwait[gnt_core_q] = 1'b0;
                    iload[int'(gnt_core_q)*WORD_W +: WORD_W] = ramload;
                end
            end
        end
    end

endmodule
